mdu_param: RTL and testbench
============================

MDU_PARAM -- requirements
Module: mdu_param

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and HI/LO width.
REQ-002 SHALL have parameter MUL_CYCLES, default 5, giving the busy cycles for mult/multu/madd; legal range is 1 or more.
REQ-003 SHALL have parameter DIV_CYCLES, default 10, giving the busy cycles for div/divu; legal range is 1 or more.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: launches a mult/div/madd operation.
REQ-007 SHALL have port mdu_mod, input, 3 bits: operation select.
REQ-008 SHALL have port a, input, WIDTH bits: operand 1 (rs), and the source for mthi/mtlo.
REQ-009 SHALL have port b, input, WIDTH bits: operand 2 (rt).
REQ-010 SHALL have port cancel, input, 1 bit: aborts an in-flight operation and suppresses same-cycle commands (exception flush).
REQ-011 SHALL have port busy, output, 1 bit: registered; high while an operation is in flight.
REQ-012 SHALL have port hi, output, WIDTH bits: the HI register.
REQ-013 SHALL have port lo, output, WIDTH bits: the LO register.

Function
REQ-014 SHALL decode mdu_mod as: 000 mul_signed, 001 mul_unsigned, 010 div_signed, 011 div_unsigned, 100 moveto_HI, 101 moveto_LO, 110 madd_signed (new), 111 none.
REQ-015 SHALL implement a two-state FSM, IDLE and BUSY, with a down-counter of width $clog2(max(MUL_CYCLES,DIV_CYCLES)+1).
REQ-016 SHALL, in IDLE, on an edge with start=1, cancel=0 and mdu_mod in {000,001,010,011,110}:
- latch the full result into pending_hi/pending_lo;
- load the counter with MUL_CYCLES or DIV_CYCLES;
- go to BUSY, with busy=1 from the next cycle.
REQ-017 SHALL, in BUSY, decrement the counter each edge; on the edge where the counter reaches 0, write hi<=pending_hi and lo<=pending_lo, set busy=0 and return to IDLE, so busy stays high for exactly N cycles.
REQ-018 SHALL, in IDLE with start=1 and mdu_mod=100, 101 or 111, take no action.
REQ-019 SHALL, for mult/multu, produce the 2*WIDTH-bit signed/unsigned product, with hi taking the upper half and lo the lower half.
REQ-020 SHALL, for madd, compute {hi,lo} + signed(a)*signed(b), modulo 2^(2*WIDTH), using the hi/lo values current at the start edge.
REQ-021 SHALL, for div/divu, set lo=quotient and hi=remainder, truncating toward zero; the remainder takes the sign of the dividend.
REQ-022 SHALL, on divide by zero, set hi=a and lo=all-ones (both signed and unsigned).
REQ-023 SHALL, on signed overflow (min_int / -1), set lo=min_int and hi=0.
REQ-024 SHALL, when mdu_mod=100 (or 101) in IDLE with cancel=0, write hi (or lo) <= a on that edge, independent of start, with 1-cycle visibility and busy unaffected.
REQ-025 SHALL, in BUSY, ignore start and moveto commands; the pipeline stalls on (start || busy) for md instructions.
REQ-026 SHALL, when cancel=1 on an edge:
- clear the counter, set busy=0 and go to IDLE;
- leave hi/lo at their pre-operation values;
- ignore any start or moveto in that same cycle;
- cancel has priority over completion on the same edge.
REQ-027 SHALL keep hi and lo unchanged on every edge without a completion, moveto or reset.

Reset
REQ-028 SHALL, on an edge with reset=1, set state=IDLE, counter=0, busy=0, hi=0, lo=0, pending_hi=0 and pending_lo=0.
REQ-029 SHALL give reset priority over cancel, start and moveto.
REQ-030 SHALL, on reset mid-operation, discard the operation with no late writeback.

Structure
REQ-031 SHALL keep the mdu_mod encodings (mdu_mul_signed … mdu_madd_signed, mdu_none) in the shared define file alongside the existing mdu_* macros.
REQ-032 SHALL place the combinational arithmetic (product, madd, quotient/remainder, div-by-zero/overflow rules) in one sub-module, mdu_arith, parametrised by WIDTH.
REQ-033 SHALL keep the FSM, counter and HI/LO registers in mdu_param.

Verification
REQ-034 SHALL verify mult: a=FFFFFFFE, b=00000003, mod=000, start -> busy=1 for 5 cycles, then hi=FFFFFFFF, lo=FFFFFFFA.
REQ-035 SHALL verify multu with the same a and b, mod=001 -> hi=00000002, lo=FFFFFFFA after 5 busy cycles.
REQ-036 SHALL verify div: a=FFFFFFF9, b=00000002, mod=010 -> busy for 10 cycles, then lo=FFFFFFFD, hi=FFFFFFFF; also verify divu a=5, b=0 -> hi=00000005, lo=FFFFFFFF.
REQ-037 SHALL verify madd: mthi 0, then mtlo 0000000A, then mod=110, a=3, b=4, start -> after 5 cycles hi=0, lo=00000016.
REQ-038 SHALL verify the BUSY-ignore rule: start a div, then in busy cycle 2 issue start with mult and mthi with a=1234 -> both ignored, and only the div result is written at cycle 10.
REQ-039 SHALL verify cancel and reset:
- cancel in busy cycle 3 of a mult -> busy=0 next cycle, hi/lo unchanged, no write at cycle 5;
- repeat with reset instead of cancel -> hi=lo=0, busy=0.

Source files
------------

// File: rtl/mdu_param_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// FSM states and small elaboration-time helpers.
package mdu_param_pkg;

   typedef enum logic [2:0] {
      mdu_mul_signed   = 3'b000,
      mdu_mul_unsigned = 3'b001,
      mdu_div_signed   = 3'b010,
      mdu_div_unsigned = 3'b011,
      mdu_moveto_hi    = 3'b100,
      mdu_moveto_lo    = 3'b101,
      mdu_madd_signed  = 3'b110,
      mdu_none         = 3'b111
   } mdu_op_e;

   typedef enum logic {
      state_idle = 1'b0,
      state_busy = 1'b1
   } mdu_state_e;

   function automatic int max_int(input int x, input int y);
      return (x > y) ? x : y;
   endfunction

   // Operations that occupy the unit for several cycles before writing HI/LO.
   function automatic logic is_md_op(input logic [2:0] op);
      return (op == mdu_mul_signed)   || (op == mdu_mul_unsigned) ||
             (op == mdu_div_signed)   || (op == mdu_div_unsigned) ||
             (op == mdu_madd_signed);
   endfunction

   function automatic logic is_div_op(input logic [2:0] op);
      return (op == mdu_div_signed) || (op == mdu_div_unsigned);
   endfunction

endpackage

// File: rtl/mdu_param_arith.sv
// Combinational arithmetic for the MDU: products, multiply-accumulate and
// quotient/remainder including the divide-by-zero and overflow rules.
module mdu_arith
   import mdu_param_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] hi,
   input  logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo
);

   localparam logic [WIDTH-1:0] MIN_INT  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ALL_ONES = '1;

   logic [2*WIDTH-1:0] prod_s;
   logic [2*WIDTH-1:0] prod_u;
   logic [2*WIDTH-1:0] madd_sum;

   logic             div_signed;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] uq;
   logic [WIDTH-1:0] ur;
   logic [WIDTH-1:0] quot;
   logic [WIDTH-1:0] rem;

   assign prod_s   = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
   assign prod_u   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
   assign madd_sum = {hi, lo} + prod_s;

   // Signed division runs on magnitudes; signs are restored afterwards so the
   // quotient truncates toward zero and the remainder follows the dividend.
   assign div_signed = (op == mdu_div_signed);
   assign a_neg      = div_signed & a[WIDTH-1];
   assign b_neg      = div_signed & b[WIDTH-1];
   assign a_mag      = a_neg ? (WIDTH'(0) - a) : a;
   assign b_mag      = b_neg ? (WIDTH'(0) - b) : b;
   assign dividend   = a_mag;
   assign divisor    = (b == '0) ? WIDTH'(1) : b_mag;
   assign uq         = dividend / divisor;
   assign ur         = dividend % divisor;
   assign quot       = (a_neg ^ b_neg) ? (WIDTH'(0) - uq) : uq;
   assign rem        = a_neg ? (WIDTH'(0) - ur) : ur;

   // Non-arithmetic encodings simply hand back the current HI/LO.
   always_comb begin
      res_hi = hi;
      res_lo = lo;
      case (op)
         mdu_mul_signed:   {res_hi, res_lo} = prod_s;
         mdu_mul_unsigned: {res_hi, res_lo} = prod_u;
         mdu_madd_signed:  {res_hi, res_lo} = madd_sum;
         mdu_div_signed,
         mdu_div_unsigned: begin
            if (b == '0) begin
               res_hi = a;
               res_lo = ALL_ONES;
            end else if (div_signed && (a == MIN_INT) && (b == ALL_ONES)) begin
               res_hi = '0;
               res_lo = MIN_INT;
            end else begin
               res_hi = rem;
               res_lo = quot;
            end
         end
         default: begin
            res_hi = hi;
            res_lo = lo;
         end
      endcase
   end

endmodule

// File: rtl/mdu_param.sv
// Multi-cycle multiply/divide unit with HI/LO registers. The result is computed
// at launch and held in a pending buffer until the busy countdown expires.
module mdu_param
   import mdu_param_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       mdu_mod,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(max_int(MUL_CYCLES, DIV_CYCLES) + 1);

   mdu_state_e       state;
   mdu_state_e       state_next;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] pending_hi;
   logic [WIDTH-1:0] pending_lo;
   logic [WIDTH-1:0] res_hi;
   logic [WIDTH-1:0] res_lo;
   logic             accept;
   logic             complete;
   logic             move_hi;
   logic             move_lo;

   mdu_arith #(
      .WIDTH(WIDTH)
   ) u_arith (
      .op     (mdu_mod),
      .a      (a),
      .b      (b),
      .hi     (hi),
      .lo     (lo),
      .res_hi (res_hi),
      .res_lo (res_lo)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= state_idle;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (cancel) begin
         state_next = state_idle;
      end else begin
         case (state)
            state_idle: if (accept)   state_next = state_busy;
            state_busy: if (complete) state_next = state_idle;
            default:                  state_next = state_idle;
         endcase
      end
   end

   // Cancel masks every command, so the decoded strobes already respect it.
   always_comb begin
      accept   = 1'b0;
      complete = 1'b0;
      move_hi  = 1'b0;
      move_lo  = 1'b0;
      if (!cancel) begin
         case (state)
            state_idle: begin
               accept  = start && is_md_op(mdu_mod);
               move_hi = (mdu_mod == mdu_moveto_hi);
               move_lo = (mdu_mod == mdu_moveto_lo);
            end
            state_busy: complete = (count <= CNT_W'(1));
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count      <= '0;
         hi         <= '0;
         lo         <= '0;
         pending_hi <= '0;
         pending_lo <= '0;
      end else if (cancel) begin
         count <= '0;
      end else begin
         if (accept) begin
            pending_hi <= res_hi;
            pending_lo <= res_lo;
            count      <= is_div_op(mdu_mod) ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
         end else if (state == state_busy) begin
            count <= count - CNT_W'(1);
         end
         if (complete) begin
            hi <= pending_hi;
            lo <= pending_lo;
         end
         if (move_hi) hi <= a;
         if (move_lo) lo <= a;
      end
   end

   assign busy = (state == state_busy);

endmodule

// File: tb/tb_mdu_param.sv
// Self-checking bench for mdu_param: directed scenarios plus randomized
// operations compared against a plain-arithmetic HI/LO model.
module tb_mdu_param;

   localparam int WIDTH      = 32;
   localparam int MUL_CYCLES = 5;
   localparam int DIV_CYCLES = 10;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              cancel;
   logic [2:0]        mdu_mod;
   logic [WIDTH-1:0]  a;
   logic [WIDTH-1:0]  b;
   logic              busy;
   logic [WIDTH-1:0]  hi;
   logic [WIDTH-1:0]  lo;

   int                tests_run    = 0;
   int                tests_failed = 0;
   logic [31:0]       model_hi     = '0;
   logic [31:0]       model_lo     = '0;

   always #5 clk = ~clk;

   mdu_param #(
      .WIDTH      (WIDTH),
      .MUL_CYCLES (MUL_CYCLES),
      .DIV_CYCLES (DIV_CYCLES)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .mdu_mod (mdu_mod),
      .a       (a),
      .b       (b),
      .cancel  (cancel),
      .busy    (busy),
      .hi      (hi),
      .lo      (lo)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      start   = 1'b0;
      cancel  = 1'b0;
      mdu_mod = 3'b111;
      a       = '0;
      b       = '0;
   endtask

   task automatic issue(input logic [2:0] mod, input logic [31:0] x, input logic [31:0] y,
                        input logic st);
      start   = st;
      mdu_mod = mod;
      a       = x;
      b       = y;
      tick();
      idle_inputs();
   endtask

   task automatic wait_idle(output int cycles);
      cycles = 0;
      while (busy === 1'b1 && cycles < 200) begin
         tick();
         cycles++;
      end
   endtask

   // Reference behaviour straight from the arithmetic rules, using 64-bit math.
   function automatic int model_latency(input logic [2:0] mod, input logic st);
      if (!st) return 0;
      case (mod)
         3'b000, 3'b001, 3'b110: return MUL_CYCLES;
         3'b010, 3'b011:         return DIV_CYCLES;
         default:                return 0;
      endcase
   endfunction

   function automatic void model_apply(input logic [2:0] mod, input logic [31:0] x,
                                       input logic [31:0] y, input logic st);
      longint      sx;
      longint      sy;
      logic [63:0] full;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      if (mod == 3'b100) model_hi = x;
      if (mod == 3'b101) model_lo = x;
      if (st) begin
         case (mod)
            3'b000: begin full = sx * sy; {model_hi, model_lo} = full; end
            3'b001: begin full = {32'b0, x} * {32'b0, y}; {model_hi, model_lo} = full; end
            3'b110: begin full = {model_hi, model_lo} + 64'(sx * sy); {model_hi, model_lo} = full; end
            3'b010: begin
               if (y == 0) begin model_hi = x; model_lo = '1; end
               else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin model_hi = '0; model_lo = x; end
               else begin model_lo = 32'(sx / sy); model_hi = 32'(sx % sy); end
            end
            3'b011: begin
               if (y == 0) begin model_hi = x; model_lo = '1; end
               else begin model_lo = x / y; model_hi = x % y; end
            end
            default: ;
         endcase
      end
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h0000_0001;
         4:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      tick();
      tick();
      reset = 1'b0;
      model_hi = '0;
      model_lo = '0;
      tests_run++;
      if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      tests_run++;
      if (hi !== 32'h0 || lo !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_hilo: got %h_%h expected 0_0", hi, lo); end
   endtask

   task automatic test_mult();
      int cyc;
      issue(3'b000, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1);
      model_apply(3'b000, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1);
      tests_run++;
      if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL mult_busy_start: got %b expected 1", busy); end
      wait_idle(cyc);
      tests_run++;
      if (cyc != MUL_CYCLES) begin tests_failed++; $display("[TB] FAIL mult_cycles: got %0d expected %0d", cyc, MUL_CYCLES); end
      tests_run++;
      if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin tests_failed++; $display("[TB] FAIL mult_result: got %h_%h expected ffffffff_fffffffa", hi, lo); end
      issue(3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1);
      model_apply(3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1);
      wait_idle(cyc);
      tests_run++;
      if (cyc != MUL_CYCLES || hi !== 32'h0000_0002 || lo !== 32'hFFFF_FFFA) begin tests_failed++; $display("[TB] FAIL multu_result: got %0d cyc %h_%h expected %0d cyc 00000002_fffffffa", cyc, hi, lo, MUL_CYCLES); end
   endtask

   task automatic test_div();
      int cyc;
      issue(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
      model_apply(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
      wait_idle(cyc);
      tests_run++;
      if (cyc != DIV_CYCLES) begin tests_failed++; $display("[TB] FAIL div_cycles: got %0d expected %0d", cyc, DIV_CYCLES); end
      tests_run++;
      if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin tests_failed++; $display("[TB] FAIL div_result: got %h_%h expected ffffffff_fffffffd", hi, lo); end
      issue(3'b011, 32'h0000_0005, 32'h0000_0000, 1'b1);
      model_apply(3'b011, 32'h0000_0005, 32'h0000_0000, 1'b1);
      wait_idle(cyc);
      tests_run++;
      if (hi !== 32'h0000_0005 || lo !== 32'hFFFF_FFFF) begin tests_failed++; $display("[TB] FAIL divu_zero: got %h_%h expected 00000005_ffffffff", hi, lo); end
      issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      model_apply(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      wait_idle(cyc);
      tests_run++;
      if (hi !== 32'h0000_0000 || lo !== 32'h8000_0000) begin tests_failed++; $display("[TB] FAIL div_overflow: got %h_%h expected 00000000_80000000", hi, lo); end
      issue(3'b010, 32'hFFFF_FFF9, 32'h0000_0000, 1'b1);
      model_apply(3'b010, 32'hFFFF_FFF9, 32'h0000_0000, 1'b1);
      wait_idle(cyc);
      tests_run++;
      if (hi !== 32'hFFFF_FFF9 || lo !== 32'hFFFF_FFFF) begin tests_failed++; $display("[TB] FAIL div_zero: got %h_%h expected fffffff9_ffffffff", hi, lo); end
   endtask

   task automatic test_madd();
      int cyc;
      issue(3'b100, 32'h0000_0000, 32'h0, 1'b0);
      model_apply(3'b100, 32'h0000_0000, 32'h0, 1'b0);
      tests_run++;
      if (hi !== 32'h0 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL mthi: got hi %h busy %b expected 0 0", hi, busy); end
      issue(3'b101, 32'h0000_000A, 32'h0, 1'b0);
      model_apply(3'b101, 32'h0000_000A, 32'h0, 1'b0);
      tests_run++;
      if (lo !== 32'h0000_000A || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL mtlo: got lo %h busy %b expected 0000000a 0", lo, busy); end
      issue(3'b110, 32'h0000_0003, 32'h0000_0004, 1'b1);
      model_apply(3'b110, 32'h0000_0003, 32'h0000_0004, 1'b1);
      wait_idle(cyc);
      tests_run++;
      if (cyc != MUL_CYCLES || hi !== 32'h0 || lo !== 32'h0000_0016) begin tests_failed++; $display("[TB] FAIL madd_result: got %0d cyc %h_%h expected %0d cyc 00000000_00000016", cyc, hi, lo, MUL_CYCLES); end
   endtask

   task automatic test_busy_ignore();
      int          cyc;
      logic [31:0] prev_hi;
      prev_hi = model_hi;
      issue(3'b010, 32'd100, 32'd7, 1'b1);
      model_apply(3'b010, 32'd100, 32'd7, 1'b1);
      tick();
      start = 1'b1; mdu_mod = 3'b000; a = 32'h1234; b = 32'd5;
      tick();
      start = 1'b0; mdu_mod = 3'b100; a = 32'h1234;
      tick();
      idle_inputs();
      tests_run++;
      if (hi !== prev_hi || busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL busy_ignore_mid: got hi %h busy %b expected %h 1", hi, busy, prev_hi); end
      wait_idle(cyc);
      tests_run++;
      if (cyc + 3 != DIV_CYCLES) begin tests_failed++; $display("[TB] FAIL busy_ignore_cycles: got %0d expected %0d", cyc + 3, DIV_CYCLES); end
      tests_run++;
      if (hi !== 32'd2 || lo !== 32'd14) begin tests_failed++; $display("[TB] FAIL busy_ignore_result: got %h_%h expected 00000002_0000000e", hi, lo); end
   endtask

   task automatic test_cancel();
      int cyc;
      issue(3'b100, 32'hAAAA_5555, 32'h0, 1'b0);
      model_apply(3'b100, 32'hAAAA_5555, 32'h0, 1'b0);
      issue(3'b101, 32'h1234_5678, 32'h0, 1'b0);
      model_apply(3'b101, 32'h1234_5678, 32'h0, 1'b0);
      issue(3'b000, 32'h0000_0007, 32'h0000_0009, 1'b1);
      tick();
      tick();
      cancel = 1'b1; start = 1'b1; mdu_mod = 3'b100; a = 32'hDEAD_BEEF;
      tick();
      idle_inputs();
      tests_run++;
      if (busy !== 1'b0 || hi !== model_hi || lo !== model_lo) begin tests_failed++; $display("[TB] FAIL cancel_mid: got busy %b %h_%h expected 0 %h_%h", busy, hi, lo, model_hi, model_lo); end
      repeat (6) tick();
      tests_run++;
      if (busy !== 1'b0 || hi !== model_hi || lo !== model_lo) begin tests_failed++; $display("[TB] FAIL cancel_late_write: got busy %b %h_%h expected 0 %h_%h", busy, hi, lo, model_hi, model_lo); end
      issue(3'b001, 32'h0000_0100, 32'h0000_0100, 1'b1);
      repeat (MUL_CYCLES - 1) tick();
      tests_run++;
      if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL cancel_last_busy: got %b expected 1", busy); end
      cancel = 1'b1;
      tick();
      idle_inputs();
      tests_run++;
      if (busy !== 1'b0 || hi !== model_hi || lo !== model_lo) begin tests_failed++; $display("[TB] FAIL cancel_vs_complete: got busy %b %h_%h expected 0 %h_%h", busy, hi, lo, model_hi, model_lo); end
      cancel = 1'b1; mdu_mod = 3'b101; a = 32'hFFFF_0000;
      tick();
      idle_inputs();
      tests_run++;
      if (lo !== model_lo) begin tests_failed++; $display("[TB] FAIL cancel_moveto: got lo %h expected %h", lo, model_lo); end
      issue(3'b000, 32'h0000_0006, 32'hFFFF_FFF9, 1'b1);
      model_apply(3'b000, 32'h0000_0006, 32'hFFFF_FFF9, 1'b1);
      wait_idle(cyc);
      tests_run++;
      if (cyc != MUL_CYCLES || hi !== model_hi || lo !== model_lo) begin tests_failed++; $display("[TB] FAIL after_cancel_op: got %0d cyc %h_%h expected %0d cyc %h_%h", cyc, hi, lo, MUL_CYCLES, model_hi, model_lo); end
   endtask

   task automatic test_reset_mid();
      issue(3'b000, 32'h0000_0011, 32'h0000_0022, 1'b1);
      tick();
      tick();
      reset = 1'b1; cancel = 1'b1; start = 1'b1; mdu_mod = 3'b100; a = 32'h5555_0000;
      tick();
      reset = 1'b0;
      idle_inputs();
      model_hi = '0;
      model_lo = '0;
      tests_run++;
      if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_mid: got busy %b %h_%h expected 0 0_0", busy, hi, lo); end
      repeat (MUL_CYCLES + 2) tick();
      tests_run++;
      if (hi !== 32'h0 || lo !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_late_write: got %h_%h expected 0_0", hi, lo); end
   endtask

   task automatic test_random();
      int          cyc;
      int          lat;
      logic [2:0]  mod;
      logic [31:0] x;
      logic [31:0] y;
      logic        st;
      for (int i = 0; i < 60; i++) begin
         mod = 3'($urandom_range(0, 7));
         st  = ($urandom_range(0, 4) != 0);
         x   = pick_operand();
         y   = pick_operand();
         lat = model_latency(mod, st);
         issue(mod, x, y, st);
         model_apply(mod, x, y, st);
         wait_idle(cyc);
         tests_run++;
         if (cyc != lat || hi !== model_hi || lo !== model_lo) begin
            tests_failed++;
            $display("[TB] FAIL random_%0d mod %b st %b a %h b %h: got %0d cyc %h_%h expected %0d cyc %h_%h",
                     i, mod, st, x, y, cyc, hi, lo, lat, model_hi, model_lo);
         end
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_mult();
      test_div();
      test_madd();
      test_busy_ignore();
      test_cancel();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
